// File: rtl/vga_scan_counter.sv
// Pixel-rate timebase and raster scan counters for the 640x480@60 display path.
// Scan registers feed the sync decode directly; strobes mark the final tick of a line/frame.
module vga_scan_counter #(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int FRAME_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_sync_clr,
    output logic               o_pix_tick,
    output logic [9:0]         o_h_count,
    output logic [9:0]         o_v_count,
    output logic               o_line_end,
    output logic               o_frame_end,
    output logic [FRAME_W-1:0] o_frame_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // The 10-bit scan counters cannot represent geometries beyond 1024.
    generate
        if (CLK_DIV < 1 || H_TOTAL < 1 || V_TOTAL < 1 || H_TOTAL > 1024 ||
            V_TOTAL > 1024 || FRAME_W < 1) begin : g_param_check
            $error("vga_scan_counter: illegal parameter value");
        end
    endgenerate

    logic [DIV_W-1:0]   div_reg;
    logic [9:0]         h_reg;
    logic [9:0]         v_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic               pix_tick;
    logic               h_last;
    logic               v_last;

    assign h_last   = (h_reg == H_LAST);
    assign v_last   = (v_reg == V_LAST);
    assign pix_tick = (div_reg == DIV_LAST) & i_en & ~i_sync_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_reg   <= '0;
            h_reg     <= '0;
            v_reg     <= '0;
            frame_reg <= '0;
        end else if (i_sync_clr) begin
            // Restart the raster but keep the frame count for game logic.
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else if (i_en) begin
            div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
            if (pix_tick) begin
                if (h_last) begin
                    h_reg <= '0;
                    if (v_last) begin
                        v_reg     <= '0;
                        frame_reg <= frame_reg + 1'b1;
                    end else begin
                        v_reg <= v_reg + 10'd1;
                    end
                end else begin
                    h_reg <= h_reg + 10'd1;
                end
            end
        end
    end

    assign o_pix_tick    = pix_tick;
    assign o_h_count     = h_reg;
    assign o_v_count     = v_reg;
    assign o_line_end    = pix_tick & h_last;
    assign o_frame_end   = pix_tick & h_last & v_last;
    assign o_frame_count = frame_reg;

endmodule

// File: tb/tb_vga_scan_counter.sv
// Directed bench: default-geometry CLK_DIV=4 instance plus a short-frame CLK_DIV=1 instance.
module tb_vga_scan_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: CLK_DIV=4, full 800x525 geometry
    logic       rst_n_a, en_a, clr_a;
    logic       tick_a, le_a, fe_a;
    logic [9:0] h_a, v_a;
    logic [15:0] fc_a;

    vga_scan_counter #(.CLK_DIV(4), .H_TOTAL(800), .V_TOTAL(525), .FRAME_W(16)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n_a), .i_en(en_a), .i_sync_clr(clr_a),
        .o_pix_tick(tick_a), .o_h_count(h_a), .o_v_count(v_a),
        .o_line_end(le_a), .o_frame_end(fe_a), .o_frame_count(fc_a));

    // Instance B: CLK_DIV=1, 800-pixel lines, 4-line frames, 2-bit frame counter
    logic       rst_n_b, en_b, clr_b;
    logic       tick_b, le_b, fe_b;
    logic [9:0] h_b, v_b;
    logic [1:0] fc_b;

    vga_scan_counter #(.CLK_DIV(1), .H_TOTAL(800), .V_TOTAL(4), .FRAME_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n_b), .i_en(en_b), .i_sync_clr(clr_b),
        .o_pix_tick(tick_b), .o_h_count(h_b), .o_v_count(v_b),
        .o_line_end(le_b), .o_frame_end(fe_b), .o_frame_count(fc_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int le_cnt, fe_cnt, tk_cnt, le_h, le_idx, fe_idx, both;

        rst_n_a = 1'b0; en_a = 1'b1; clr_a = 1'b0;
        rst_n_b = 1'b0; en_b = 1'b1; clr_b = 1'b0;
        #1;
        check("a_rst_h",    32'(h_a), 0);
        check("a_rst_v",    32'(v_a), 0);
        check("a_rst_fc",   32'(fc_a), 0);
        check("a_rst_tick", 32'(tick_a), 0);
        check("a_rst_le",   32'(le_a), 0);

        // First tick in the window after the 3rd edge, h advances on the 4th
        step(1);
        rst_n_a = 1'b1;
        step(2);
        check("a_pre_tick", 32'(tick_a), 0);
        step(1);
        check("a_first_tick", 32'(tick_a), 1);
        check("a_first_tick_h", 32'(h_a), 0);
        step(1);
        check("a_h_after_tick", 32'(h_a), 1);
        check("a_v_after_tick", 32'(v_a), 0);
        check("a_tick_low", 32'(tick_a), 0);
        step(2);
        check("a_tick_gap3", 32'(tick_a), 0);
        step(1);
        check("a_tick_period4", 32'(tick_a), 1);

        // Finish the line: h=1, div=3 now; wrap happens 3193 edges later
        le_cnt = 0; fe_cnt = 0; le_h = -1;
        for (int i = 1; i <= 3193; i++) begin
            step(1);
            if (le_a) begin le_cnt++; le_h = int'(h_a); end
            if (fe_a) fe_cnt++;
        end
        check("a_line_end_count", 32'(le_cnt), 1);
        check("a_line_end_h",     32'(le_h), 799);
        check("a_frame_end_none", 32'(fe_cnt), 0);
        check("a_line_wrap_h",    32'(h_a), 0);
        check("a_line_wrap_v",    32'(v_a), 1);

        // Reach h=300, div=2, then freeze for 37 clocks
        step(1202);
        check("a_pos_h300", 32'(h_a), 300);
        en_a = 1'b0;
        tk_cnt = 0;
        for (int i = 0; i < 37; i++) begin
            step(1);
            if (tick_a) tk_cnt++;
        end
        check("a_hold_ticks", 32'(tk_cnt), 0);
        check("a_hold_h", 32'(h_a), 300);
        check("a_hold_v", 32'(v_a), 1);
        en_a = 1'b1;
        step(1);
        check("a_resume_tick", 32'(tick_a), 1);
        check("a_resume_h_before", 32'(h_a), 300);
        step(1);
        check("a_resume_h", 32'(h_a), 301);

        // Asynchronous reset between edges
        #3;
        rst_n_a = 1'b0;
        #1;
        check("a_async_h", 32'(h_a), 0);
        check("a_async_v", 32'(v_a), 0);
        check("a_async_tick", 32'(tick_a), 0);
        step(1);
        rst_n_a = 1'b1;

        // Sync clear at div=3 must restart the divider
        step(3);
        check("a_clr_pre_tick", 32'(tick_a), 1);
        clr_a = 1'b1;
        #1;
        check("a_clr_masks_tick", 32'(tick_a), 0);
        step(1);
        clr_a = 1'b0;
        check("a_clr_h", 32'(h_a), 0);
        check("a_clr_tick_after", 32'(tick_a), 0);
        step(2);
        check("a_clr_no_early_tick", 32'(tick_a), 0);
        step(1);
        check("a_clr_tick_restart", 32'(tick_a), 1);

        // Instance B: CLK_DIV=1 ticks every enabled cycle
        rst_n_b = 1'b1;
        #1;
        check("b_tick_immediate", 32'(tick_b), 1);
        le_cnt = 0; fe_cnt = 0; tk_cnt = 0; le_idx = -1; fe_idx = -1; both = 0;
        for (int i = 1; i <= 3200; i++) begin
            step(1);
            if (i <= 800 && tick_b) tk_cnt++;
            if (le_b) begin
                le_cnt++;
                if (le_idx < 0) le_idx = i;
            end
            if (fe_b) begin
                fe_cnt++;
                fe_idx = i;
                if (le_b && h_b == 10'd799 && v_b == 10'd3) both++;
            end
            if (i == 800) begin
                check("b_line_wrap_h", 32'(h_b), 0);
                check("b_line_wrap_v", 32'(v_b), 1);
            end
        end
        check("b_tick_every_cycle", 32'(tk_cnt), 800);
        check("b_first_line_end", 32'(le_idx), 799);
        check("b_line_end_count", 32'(le_cnt), 4);
        check("b_frame_end_count", 32'(fe_cnt), 1);
        check("b_frame_end_at", 32'(fe_idx), 3199);
        check("b_frame_end_with_le", 32'(both), 1);
        check("b_frame_wrap_h", 32'(h_b), 0);
        check("b_frame_wrap_v", 32'(v_b), 0);
        check("b_frame_count1", 32'(fc_b), 1);

        step(6400);
        check("b_frame_count3", 32'(fc_b), 3);
        step(3199);
        check("b_last_tick_fe", 32'(fe_b), 1);

        // Sync clear on the final tick of a frame
        clr_b = 1'b1;
        #1;
        check("b_clr_fe", 32'(fe_b), 0);
        check("b_clr_le", 32'(le_b), 0);
        check("b_clr_tick", 32'(tick_b), 0);
        step(1);
        check("b_clr_h", 32'(h_b), 0);
        check("b_clr_v", 32'(v_b), 0);
        check("b_clr_fc_kept", 32'(fc_b), 3);
        clr_b = 1'b0;

        // Natural 2-bit wrap of the frame counter
        step(3200);
        check("b_fc_wrap", 32'(fc_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
